// File: rtl/ts_pkt_pack512.sv
// ts_pkt_pack512
// Byte-wide MPEG-TS packer for the clk_ts domain. Hunts for a 0x47 start of
// packet, assembles 188 bytes, prepends a 4-byte header (tag, channel, packet
// count) and writes the 192-byte record as three 512-bit RAM words. Aborted,
// sync-invalid or back-pressured packets never reach the RAM.
module ts_pkt_pack512 #(
  parameter logic [7:0] CHAN_ID = 8'h00,
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input  logic         clk_ts,
  input  logic         rst_ts_n,
  input  logic [7:0]   ts_din,
  input  logic         ts_din_vld,
  input  logic         ts_din_sop,
  input  logic         ts_ram_afull,
  output logic         ts_ram_wr,
  output logic [511:0] ts_ram_wdata,
  output logic [15:0]  pkt_cnt,
  output logic [15:0]  drop_cnt,
  output logic         sync_err
);

  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam logic [7:0] LAST_IDX  = 8'd187;

  typedef enum logic {RX_HUNT, RX_COLLECT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_W0, TX_W1, TX_W2} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;
  logic [7:0]    idx;
  logic [1495:0] asm_sr;
  logic [1535:0] snap;
  logic [1535:0] snap_next;

  logic sop_ok;
  logic sop_bad;
  logic early_sop;
  logic store_byte;
  logic last_byte;
  logic commit_ok;
  logic commit_drop;

  // Byte classification; the assembly register holds TS bytes 0..186 when the
  // 188th byte arrives, so that byte is taken straight from ts_din at commit.
  assign sop_ok      = ts_din_vld && ts_din_sop && (ts_din == SYNC_BYTE);
  assign sop_bad     = ts_din_vld && ts_din_sop && (ts_din != SYNC_BYTE) && (rx_state == RX_HUNT);
  assign early_sop   = ts_din_vld && ts_din_sop && (rx_state == RX_COLLECT);
  assign store_byte  = sop_ok || (ts_din_vld && !ts_din_sop && (rx_state == RX_COLLECT));
  assign last_byte   = ts_din_vld && !ts_din_sop && (rx_state == RX_COLLECT) && (idx == LAST_IDX);
  assign commit_ok   = last_byte && !ts_ram_afull;
  assign commit_drop = last_byte && ts_ram_afull;
  assign snap_next   = {HDR_TAG, CHAN_ID, pkt_cnt, asm_sr, ts_din};

  // Receive FSM: hunt for a sync-valid sop, then count bytes up to the last one
  always_ff @(posedge clk_ts or negedge rst_ts_n) begin
    if (!rst_ts_n) begin
      rx_state <= RX_HUNT;
      idx      <= 8'd0;
    end else if (ts_din_vld) begin
      if (ts_din_sop) begin
        if (ts_din == SYNC_BYTE) begin
          rx_state <= RX_COLLECT;
          idx      <= 8'd1;
        end else begin
          rx_state <= RX_HUNT;
          idx      <= 8'd0;
        end
      end else if (rx_state == RX_COLLECT) begin
        if (idx == LAST_IDX) begin
          rx_state <= RX_HUNT;
          idx      <= 8'd0;
        end else begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

  // Packet data path: shift in accepted bytes, freeze the record on commit
  always_ff @(posedge clk_ts) begin
    if (store_byte) asm_sr <= {asm_sr[1487:0], ts_din};
    if (commit_ok)  snap   <= snap_next;
  end

  // Status: packet counter wraps, drop counter saturates, single error pulse
  always_ff @(posedge clk_ts or negedge rst_ts_n) begin
    if (!rst_ts_n) begin
      pkt_cnt  <= 16'd0;
      drop_cnt <= 16'd0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= sop_bad || early_sop;
      if (commit_ok) pkt_cnt <= pkt_cnt + 16'd1;
      if ((early_sop || commit_drop) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Transmit FSM: three consecutive write cycles starting right after commit
  always_ff @(posedge clk_ts or negedge rst_ts_n) begin
    if (!rst_ts_n) begin
      tx_state  <= TX_IDLE;
      ts_ram_wr <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (commit_ok) begin
            tx_state  <= TX_W0;
            ts_ram_wr <= 1'b1;
          end
        end
        TX_W0: tx_state <= TX_W1;
        TX_W1: tx_state <= TX_W2;
        TX_W2: begin
          tx_state  <= TX_IDLE;
          ts_ram_wr <= 1'b0;
        end
      endcase
    end
  end

  // Word select from the frozen record; zero whenever no write is in progress
  always_comb begin
    ts_ram_wdata = '0;
    case (tx_state)
      TX_W0:   ts_ram_wdata = snap[1535:1024];
      TX_W1:   ts_ram_wdata = snap[1023:512];
      TX_W2:   ts_ram_wdata = snap[511:0];
      default: ts_ram_wdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ts_pkt_pack512.sv
// tb_ts_pkt_pack512
// Scoreboard bench: expected record words are queued as packets are driven and
// popped when the packer writes; counters and error pulses are compared to a model.
module tb_ts_pkt_pack512;

  logic         clk_ts = 1'b0;
  logic         rst_ts_n;
  logic [7:0]   ts_din;
  logic         ts_din_vld;
  logic         ts_din_sop;
  logic         ts_ram_afull;
  logic         ts_ram_wr;
  logic [511:0] ts_ram_wdata;
  logic [15:0]  pkt_cnt;
  logic [15:0]  drop_cnt;
  logic         sync_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_byte_cyc = 0;
  int prev_wr_cyc   = 0;
  int word_idx      = 0;
  int se_cnt        = 0;
  int exp_se        = 0;
  logic [15:0]  exp_pkt;
  logic [15:0]  exp_drop;
  logic [511:0] last_word0;
  logic [511:0] exp_q[$];
  logic [7:0]   pkt [0:187];

  ts_pkt_pack512 #(.CHAN_ID(8'h00), .HDR_TAG(8'hA5)) dut (
    .clk_ts       (clk_ts),
    .rst_ts_n     (rst_ts_n),
    .ts_din       (ts_din),
    .ts_din_vld   (ts_din_vld),
    .ts_din_sop   (ts_din_sop),
    .ts_ram_afull (ts_ram_afull),
    .ts_ram_wr    (ts_ram_wr),
    .ts_ram_wdata (ts_ram_wdata),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt),
    .sync_err     (sync_err)
  );

  // Free-running clock and cycle counter
  always #5 clk_ts = ~clk_ts;
  always @(posedge clk_ts) cyc++;

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Monitor: compare each written word with the scoreboard, check timing, count error pulses
  always @(negedge clk_ts) begin
    if (!rst_ts_n) begin
      word_idx = 0;
    end else begin
      if (sync_err) se_cnt++;
      if (ts_ram_wr) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_wr", 512'd1, 512'd0);
        end else begin
          checkOutput("wdata", ts_ram_wdata, exp_q.pop_front());
        end
        if (word_idx == 0) begin
          checkOutput("wr_latency", 512'(cyc - last_byte_cyc), 512'd1);
          last_word0 = ts_ram_wdata;
        end else begin
          checkOutput("wr_consecutive", 512'(cyc - prev_wr_cyc), 512'd1);
        end
        prev_wr_cyc = cyc;
        word_idx = (word_idx == 2) ? 0 : word_idx + 1;
      end else if (ts_ram_wdata != '0) begin
        checkOutput("idle_wdata", ts_ram_wdata, 512'd0);
      end
    end
  end

  task automatic fillPacket(input int seed);
    pkt[0] = 8'h47;
    for (int i = 1; i < 188; i++) pkt[i] = 8'(i * seed + 3 * seed + 1);
  endtask

  task automatic pushRecord();
    logic [1535:0] rec;
    rec = '0;
    rec[1535:1504] = {8'hA5, 8'h00, exp_pkt};
    for (int i = 0; i < 188; i++) rec[1503 - 8 * i -: 8] = pkt[i];
    exp_q.push_back(rec[1535:1024]);
    exp_q.push_back(rec[1023:512]);
    exp_q.push_back(rec[511:0]);
    exp_pkt++;
  endtask

  // Drive pkt[0..n-1] with sop on byte 0, optional random vld gaps and afull on the last byte
  task automatic applyStimulus(input int n, input int gap_pct, input bit afull_last, input bit expect_commit);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && int'($urandom_range(99)) < gap_pct) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk_ts); #1;
          ts_din       = 8'($urandom_range(255));
          ts_din_sop   = 1'($urandom_range(1));
          ts_din_vld   = 1'b0;
          ts_ram_afull = 1'b0;
        end
      end
      if (i == n - 1 && expect_commit) pushRecord();
      @(posedge clk_ts); #1;
      ts_din       = pkt[i];
      ts_din_vld   = 1'b1;
      ts_din_sop   = (i == 0);
      ts_ram_afull = afull_last && (i == n - 1);
      if (i == n - 1) last_byte_cyc = cyc;
    end
    @(posedge clk_ts); #1;
    ts_din_vld   = 1'b0;
    ts_din_sop   = 1'b0;
    ts_ram_afull = 1'b0;
  endtask

  task automatic doReset();
    rst_ts_n     = 1'b0;
    ts_din_vld   = 1'b0;
    ts_din_sop   = 1'b0;
    ts_ram_afull = 1'b0;
    ts_din       = 8'h00;
    exp_q.delete();
    exp_pkt  = 16'd0;
    exp_drop = 16'd0;
    repeat (3) @(posedge clk_ts);
    @(negedge clk_ts);
    rst_ts_n = 1'b1;
  endtask

  // Bounded wait for the scoreboard to empty, then compare counters with the model
  task automatic drainAndCheck(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk_ts);
    repeat (5) @(negedge clk_ts);
    checkOutput({tag, "_drain"}, 512'(exp_q.size()), 512'd0);
    checkOutput({tag, "_pkt_cnt"}, 512'(pkt_cnt), 512'(exp_pkt));
    checkOutput({tag, "_drop_cnt"}, 512'(drop_cnt), 512'(exp_drop));
    checkOutput({tag, "_sync_err"}, 512'(se_cnt), 512'(exp_se));
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence
  initial begin
    doReset();
    checkOutput("rst_wr", 512'(ts_ram_wr), 512'd0);
    checkOutput("rst_wdata", ts_ram_wdata, 512'd0);
    checkOutput("rst_pkt_cnt", 512'(pkt_cnt), 512'd0);
    checkOutput("rst_drop_cnt", 512'(drop_cnt), 512'd0);
    checkOutput("rst_sync_err", 512'(sync_err), 512'd0);

    $display("[TB] test 1: single back-to-back packet");
    for (int i = 0; i < 188; i++) pkt[i] = 8'h00;
    pkt[0] = 8'h47; pkt[1] = 8'h1F; pkt[2] = 8'hFE; pkt[3] = 8'h13;
    applyStimulus(188, 0, 1'b0, 1'b1);
    drainAndCheck("t1");
    checkOutput("t1_hdr", 512'(last_word0[511:480]), 512'h A500_0000);
    checkOutput("t1_byte0", 512'(last_word0[479:472]), 512'h47);

    $display("[TB] test 2: same packet with vld gaps");
    applyStimulus(188, 40, 1'b0, 1'b1);
    drainAndCheck("t2");

    $display("[TB] test 3: early sop at byte 100");
    doReset();
    fillPacket(3);
    applyStimulus(100, 0, 1'b0, 1'b0);
    fillPacket(11);
    exp_drop++;
    exp_se++;
    applyStimulus(188, 0, 1'b0, 1'b1);
    drainAndCheck("t3");
    checkOutput("t3_hdr", 512'(last_word0[511:480]), 512'h A500_0000);

    $display("[TB] test 4: bad sync byte");
    doReset();
    fillPacket(5);
    pkt[0] = 8'h46;
    exp_se++;
    applyStimulus(188, 0, 1'b0, 1'b0);
    drainAndCheck("t4_bad");
    fillPacket(7);
    applyStimulus(188, 20, 1'b0, 1'b1);
    drainAndCheck("t4_good");

    $display("[TB] test 5: afull at last byte");
    fillPacket(9);
    exp_drop++;
    applyStimulus(188, 0, 1'b1, 1'b0);
    drainAndCheck("t5_afull");
    fillPacket(13);
    applyStimulus(188, 0, 1'b0, 1'b1);
    drainAndCheck("t5_next");

    $display("[TB] test 6: reset during second word");
    fillPacket(17);
    applyStimulus(188, 0, 1'b0, 1'b1);
    @(posedge clk_ts); #1;
    rst_ts_n = 1'b0;
    #1;
    checkOutput("t6_rst_wr", 512'(ts_ram_wr), 512'd0);
    checkOutput("t6_rst_wdata", ts_ram_wdata, 512'd0);
    exp_q.delete();
    exp_pkt  = 16'd0;
    exp_drop = 16'd0;
    repeat (2) @(posedge clk_ts);
    @(negedge clk_ts);
    rst_ts_n = 1'b1;
    repeat (20) @(negedge clk_ts);
    drainAndCheck("t6_after_rst");
    fillPacket(19);
    applyStimulus(188, 10, 1'b0, 1'b1);
    drainAndCheck("t6_restart");
    checkOutput("t6_hdr", 512'(last_word0[511:480]), 512'h A500_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
